// File: rtl/seg_meter.sv
// seg_meter: edge/duty meter over a gate of sample words, with a serial
// 7-segment readout through a 74HC595-style chain (ds/shclk/stclk),
// a debounced page key, a hold key and sticky saturation flags.
module seg_meter #(
   parameter int W      = 32,
   parameter int GATE   = 31_250_000,
   parameter int CW     = 32,
   parameter int DIGITS = 8,
   parameter int DIV    = 1,
   parameter int DEB    = 1_000_000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          smp_vld,
   input  logic [W-1:0]  smp,
   input  logic          key0,
   input  logic          key1,
   output logic [CW-1:0] freq,
   output logic [CW-1:0] duty,
   output logic          meas_done,
   output logic          ds,
   output logic          shclk,
   output logic          stclk,
   output logic [3:0]    led
);

   localparam int EW  = $clog2(W + 1);
   localparam int GW  = $clog2(GATE + 1);
   localparam int DBW = $clog2(DEB + 1);
   localparam int DVW = $clog2(DIV + 1);
   localparam int SW  = (CW > 32) ? CW : 32;

   logic [CW-1:0] facc, dacc, hf, hd;
   logic [GW-1:0] gcnt;
   logic          prev_msb, have_prev, ovf_f, ovf_d, hold;
   logic [1:0]    page;
   logic [W-1:0]  edg;
   logic [EW-1:0] e, o;
   logic [CW:0]   fsum, dsum;
   logic [CW-1:0] fsat, dsat;

   // per-word edge and high-bit counts; the very first word after reset has
   // no predecessor, so its bit 0 is not compared against anything
   always_comb begin
      edg = smp ^ {smp[W-2:0], have_prev ? prev_msb : smp[0]};
      e   = '0;
      o   = '0;
      for (int i = 0; i < W; i++) begin
         e = e + EW'(edg[i]);
         o = o + EW'(smp[i]);
      end
      fsum = {1'b0, facc} + (CW+1)'(e);
      dsum = {1'b0, dacc} + (CW+1)'(o);
      fsat = fsum[CW] ? {CW{1'b1}} : fsum[CW-1:0];
      dsat = dsum[CW] ? {CW{1'b1}} : dsum[CW-1:0];
   end

   // window accumulation, result latch and sticky overflow flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         facc      <= '0;
         dacc      <= '0;
         gcnt      <= '0;
         prev_msb  <= 1'b0;
         have_prev <= 1'b0;
         freq      <= '0;
         duty      <= '0;
         meas_done <= 1'b0;
         ovf_f     <= 1'b0;
         ovf_d     <= 1'b0;
      end else begin
         meas_done <= 1'b0;
         if (smp_vld) begin
            prev_msb  <= smp[W-1];
            have_prev <= 1'b1;
            if (fsum[CW]) ovf_f <= 1'b1;
            if (dsum[CW]) ovf_d <= 1'b1;
            if (gcnt == GW'(GATE - 1)) begin
               freq      <= fsat;
               duty      <= dsat;
               facc      <= '0;
               dacc      <= '0;
               gcnt      <= '0;
               meas_done <= 1'b1;
            end else begin
               facc <= fsat;
               dacc <= dsat;
               gcnt <= gcnt + 1'b1;
            end
         end
      end
   end

   logic [1:0]     k_s1, k_s2, k_lvl, k_ev;
   logic [DBW-1:0] k_cnt [2];

   // a key event is the sample that completes a stable run of DEB lows
   always_comb begin
      for (int i = 0; i < 2; i++)
         k_ev[i] = k_lvl[i] & ~k_s2[i] & (k_cnt[i] == DBW'(DEB - 1));
   end

   // key synchronizers and debounce run counters (keys idle high)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_s1  <= 2'b11;
         k_s2  <= 2'b11;
         k_lvl <= 2'b11;
         for (int i = 0; i < 2; i++) k_cnt[i] <= '0;
      end else begin
         k_s1 <= {key1, key0};
         k_s2 <= k_s1;
         for (int i = 0; i < 2; i++) begin
            if (k_s2[i] == k_lvl[i]) begin
               k_cnt[i] <= '0;
            end else if (k_cnt[i] == DBW'(DEB - 1)) begin
               k_lvl[i] <= k_s2[i];
               k_cnt[i] <= '0;
            end else begin
               k_cnt[i] <= k_cnt[i] + 1'b1;
            end
         end
      end
   end

   // page rotation and hold toggle with snapshot of the displayed values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         page <= 2'd0;
         hold <= 1'b0;
         hf   <= '0;
         hd   <= '0;
      end else begin
         if (k_ev[0]) page <= (page == 2'd2) ? 2'd0 : page + 2'd1;
         if (k_ev[1]) begin
            hold <= ~hold;
            if (!hold) begin
               hf <= freq;
               hd <= duty;
            end
         end
      end
   end

   assign led = {ovf_d, hold, page};

   logic [SW-1:0] src;
   logic [2:0]    dig;
   logic [3:0]    nib;
   logic [7:0]    seg;
   logic [15:0]   nframe;

   // next frame contents: digit select plus active-low segment pattern
   always_comb begin
      case (page)
         2'd0:    src = SW'(hold ? hf : freq);
         2'd1:    src = SW'(hold ? hd : duty);
         default: src = SW'({ovf_d, ovf_f});
      endcase
      nib = src[{dig, 2'b00} +: 4];
      case (nib)
         4'h0: seg = 8'h03;  4'h1: seg = 8'h9F;  4'h2: seg = 8'h25;  4'h3: seg = 8'h0D;
         4'h4: seg = 8'h99;  4'h5: seg = 8'h49;  4'h6: seg = 8'h41;  4'h7: seg = 8'h1F;
         4'h8: seg = 8'h01;  4'h9: seg = 8'h09;  4'hA: seg = 8'h11;  4'hB: seg = 8'hC1;
         4'hC: seg = 8'h63;  4'hD: seg = 8'h85;  4'hE: seg = 8'h61;  default: seg = 8'h71;
      endcase
      nframe = {8'h80 >> dig, seg};
   end

   logic [5:0]     step;
   logic [DVW-1:0] divc;
   logic [14:0]    sreg;

   // serializer: steps 0..31 are bit low/high halves, 32 latch, 33 idle;
   // each step lasts DIV cycles and the frame is captured at step 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step  <= 6'd33;
         divc  <= '0;
         sreg  <= '0;
         dig   <= '0;
         ds    <= 1'b0;
         shclk <= 1'b0;
         stclk <= 1'b0;
      end else if (divc != '0) begin
         divc <= divc - 1'b1;
      end else begin
         divc <= DVW'(DIV - 1);
         if (step == 6'd33) begin
            step  <= 6'd0;
            ds    <= nframe[0];
            sreg  <= nframe[15:1];
            shclk <= 1'b0;
            stclk <= 1'b0;
            dig   <= (dig == 3'(DIGITS - 1)) ? 3'd0 : dig + 3'd1;
         end else begin
            step <= step + 6'd1;
            if (step == 6'd31) begin
               shclk <= 1'b0;
               stclk <= 1'b1;
            end else if (step == 6'd32) begin
               stclk <= 1'b0;
            end else if (step[0]) begin
               ds    <= sreg[0];
               sreg  <= sreg >> 1;
               shclk <= 1'b0;
            end else begin
               shclk <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_meter.sv
// Bench for seg_meter: two instances (wide accumulators / 4-bit saturating),
// window results checked through a scoreboard queue, display frames decoded
// from the serial chain and compared against the expected display value.
module tb_seg_meter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vld0 = 1'b0, vld1 = 1'b0;
   logic [7:0]  smp0 = '0, smp1 = '0;
   logic        key0a = 1'b1, key1a = 1'b1, key_idle = 1'b1;
   logic [31:0] freq0, duty0;
   logic [3:0]  freq1, duty1, led0, led1;
   logic        md0, md1, ds0, sh0, st0, ds1, sh1, st1;

   int errors = 0;
   int checks = 0;
   int frames = 0;

   always #5 clk = ~clk;

   seg_meter #(.W(8), .GATE(4), .CW(32), .DIGITS(8), .DIV(1), .DEB(4)) u0 (
      .clk(clk), .rst(rst), .smp_vld(vld0), .smp(smp0), .key0(key0a), .key1(key1a),
      .freq(freq0), .duty(duty0), .meas_done(md0), .ds(ds0), .shclk(sh0),
      .stclk(st0), .led(led0));

   seg_meter #(.W(8), .GATE(2), .CW(4), .DIGITS(8), .DIV(1), .DEB(4)) u1 (
      .clk(clk), .rst(rst), .smp_vld(vld1), .smp(smp1), .key0(key_idle), .key1(key_idle),
      .freq(freq1), .duty(duty1), .meas_done(md1), .ds(ds1), .shclk(sh1),
      .stclk(st1), .led(led1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] segtab(input logic [3:0] n);
      case (n)
         4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
         4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
         4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'h11;  4'hB: return 8'hC1;
         4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
      endcase
   endfunction

   // scoreboard queues: {freq, duty} expected at each meas_done
   logic [63:0] q0[$];
   logic [7:0]  q1[$];
   logic [63:0] e0;
   logic [7:0]  e1;

   always @(negedge clk) begin
      if (!rst) begin
         if (md0) begin
            if (q0.size() == 0) chk("u0_unexpected_meas_done", 1, 0);
            else begin
               e0 = q0.pop_front();
               chk("u0_freq", freq0, e0[63:32]);
               chk("u0_duty", duty0, e0[31:0]);
            end
         end
         if (md1) begin
            if (q1.size() == 0) chk("u1_unexpected_meas_done", 1, 0);
            else begin
               e1 = q1.pop_front();
               chk("u1_freq", freq1, e1[7:4]);
               chk("u1_duty", duty1, e1[3:0]);
            end
         end
      end
   end

   // frame monitor on u0's serial chain
   logic [31:0] exp_disp = '0;
   logic        chk_en = 1'b0;
   logic        sh_q, st_q;
   logic [15:0] fr, fexp;
   int          nb, cyc = 0, last_rise, st_hi, k;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         nb = 0; last_rise = -1; sh_q = 1'b0; st_q = 1'b0; st_hi = 0;
      end else begin
         if (sh0 && !sh_q) begin
            if (nb < 16) fr[nb] = ds0;
            nb++;
         end
         if (st0 && !st_q) begin
            if (chk_en) begin
               chk("frame_bits", nb, 16);
               if (last_rise >= 0) chk("frame_period", cyc - last_rise, 34);
               k = 0;
               for (int j = 0; j < 8; j++) if (fr[15-j]) k = j;
               fexp = {8'h80 >> k, segtab(4'((exp_disp >> (4*k)) & 32'hF))};
               chk("frame", fr, fexp);
               frames++;
            end
            last_rise = cyc;
            nb = 0;
         end
         if (!st0 && st_q && chk_en) chk("stclk_width", st_hi, 1);
         st_hi = st0 ? st_hi + 1 : 0;
         sh_q = sh0;
         st_q = st0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [7:0] v);
      vld0 = 1'b1; smp0 = v; step(1); vld0 = 1'b0;
   endtask

   task automatic send1(input logic [7:0] v);
      vld1 = 1'b1; smp1 = v; step(1); vld1 = 1'b0;
   endtask

   task automatic press(input int which);
      if (which == 0) key0a = 1'b0; else key1a = 1'b0;
      step(10);
      key0a = 1'b1; key1a = 1'b1;
      step(10);
   endtask

   task automatic show(input logic [31:0] v);
      chk_en = 1'b0;
      exp_disp = v;
      step(40);
      chk_en = 1'b1;
      step(300);
      chk_en = 1'b0;
   endtask

   initial begin
      // samples presented during reset must be ignored
      vld0 = 1'b1; smp0 = 8'hFF; vld1 = 1'b1; smp1 = 8'hFF;
      @(negedge clk); @(negedge clk);
      chk("rst_freq", freq0, 0);
      chk("rst_duty", duty0, 0);
      chk("rst_meas_done", md0, 0);
      chk("rst_ds", ds0, 0);
      chk("rst_shclk", sh0, 0);
      chk("rst_stclk", st0, 0);
      chk("rst_led", led0, 0);
      step(1);
      rst = 1'b0; vld0 = 1'b0; vld1 = 1'b0;

      // partial window then reset: partial counts discarded
      send0(8'hFF); send0(8'hFF);
      rst = 1'b1; step(2); rst = 1'b0;
      chk("no_result_after_partial", freq0, 0);

      // 0x55 x4: 7+8+8+8 edges, 16 high bits
      send0(8'h55); send0(8'h55); send0(8'h55);
      q0.push_back({32'd31, 32'd16}); send0(8'h55);
      step(3);
      chk("u0_led_no_ovf", led0, 4'h0);

      // u1 gapless then gapped: same words give same result
      send1(8'h0E); q1.push_back({4'd4, 4'd7}); send1(8'h3C);
      step(2);
      send1(8'h0E); step(3); q1.push_back({4'd4, 4'd7}); send1(8'h3C);
      step(3);

      // saturation: duty 8+8 clips to 15, sticky ovf_d
      send1(8'hFF); q1.push_back({4'd1, 4'd15}); send1(8'hFF);
      step(2);
      chk("u1_ovf_d_set", led1[3], 1);
      send1(8'h00); q1.push_back({4'd1, 4'd0}); send1(8'h00);
      step(2);
      chk("u1_ovf_d_sticky", led1[3], 1);

      // display: page 0 shows freq 0x1F
      show(32'h0000_001F);

      // bounced press advances page exactly once
      key0a = 1'b0; step(1); key0a = 1'b1; step(1); key0a = 1'b0; step(10);
      key0a = 1'b1; step(10);
      chk("page_after_bounce", led0, 4'h1);
      show(32'h0000_0010);
      press(0);
      chk("page_2", led0, 4'h2);
      show(32'h0000_0000);
      press(0);
      chk("page_wrap", led0, 4'h0);

      // hold: new window updates the port, display keeps the snapshot
      press(1);
      chk("hold_on", led0, 4'h4);
      exp_disp = 32'h0000_001F;
      chk_en = 1'b1;
      send0(8'h0F); send0(8'h0F); send0(8'h0F);
      q0.push_back({32'd8, 32'd16}); send0(8'h0F);
      step(300);
      chk_en = 1'b0;
      press(1);
      chk("hold_off", led0, 4'h0);
      show(32'h0000_0008);

      chk("u0_queue_drained", q0.size(), 0);
      chk("u1_queue_drained", q1.size(), 0);
      chk("frames_seen", frames >= 40, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
